// File: rtl/alu_pipe_nch.sv
// alu_pipe_nch: multi-channel two-stage ALU with accumulators, valid/ready handshake and XOR/parity reduction
module alu_pipe_nch #(
  parameter int WIDTH  = 8,
  parameter int NCH    = 2,
  parameter int ACC_EN = 1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*WIDTH-1:0] a_i,
  input  logic [NCH*WIDTH-1:0] b_i,
  input  logic [NCH*3-1:0]     op_i,
  input  logic                 acc_clr_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*WIDTH-1:0] res_o,
  output logic [NCH-1:0]       carry_o,
  output logic [WIDTH-1:0]     xor_o,
  output logic                 par_o
);
  logic                 r_s1_valid;
  logic                 r_s2_valid;
  logic [NCH*WIDTH-1:0] r_a;
  logic [NCH*WIDTH-1:0] r_b;
  logic [NCH*3-1:0]     r_op;
  logic [NCH*WIDTH-1:0] r_res;
  logic [NCH-1:0]       r_carry;
  logic [WIDTH-1:0]     r_xor;
  logic                 r_par;
  logic                 w_adv2;
  logic                 w_accept;
  logic [NCH*WIDTH-1:0] w_res;
  logic [NCH-1:0]       w_carry;
  logic [WIDTH-1:0]     w_xor;

  assign w_adv2    = r_s1_valid & (~r_s2_valid | out_ready);
  assign in_ready  = wb_rst_n_i & (~r_s1_valid | w_adv2);
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_s2_valid;
  assign res_o     = r_res;
  assign carry_o   = r_carry;
  assign xor_o     = r_xor;
  assign par_o     = r_par;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [2:0]       w_op;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_acc;
    logic [WIDTH:0]   w_r;
    logic             w_is_acc;
    logic [WIDTH-1:0] r_acc;
    assign w_a      = r_a[k*WIDTH +: WIDTH];
    assign w_b      = r_b[k*WIDTH +: WIDTH];
    assign w_op     = r_op[k*3 +: 3];
    assign w_base   = acc_clr_i ? '0 : r_acc;
    assign w_sum    = {1'b0, w_a} + {1'b0, w_b};
    assign w_acc    = {1'b0, w_base} + {1'b0, w_a};
    assign w_is_acc = (ACC_EN != 0) && (w_op == 3'b110);
    // per-channel opcode decode; carry lives in bit WIDTH of w_r
    always_comb begin
      case (w_op)
        3'b000:  w_r = w_sum;
        3'b001:  w_r = {w_a >= w_b, w_a - w_b};
        3'b010:  w_r = {1'b0, w_a & w_b};
        3'b011:  w_r = {1'b0, w_a | w_b};
        3'b100:  w_r = {1'b0, w_a ^ w_b};
        3'b101:  w_r = {1'b0, ~(w_a ^ w_b)};
        3'b110:  w_r = w_is_acc ? w_acc : w_sum;
        default: w_r = {w_a > w_b, (w_a >= w_b) ? w_a : w_b};
      endcase
    end
    assign w_res[k*WIDTH +: WIDTH] = w_r[WIDTH-1:0];
    assign w_carry[k]              = w_r[WIDTH];
    // accumulator: an advancing ACC op wins (it already folds in the clear), otherwise a clear zeroes it
    always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) r_acc <= '0;
      else if (w_adv2 && w_is_acc) r_acc <= w_acc[WIDTH-1:0];
      else if (acc_clr_i) r_acc <= '0;
    end
  end

  // XOR-reduce all channel results of the bundle entering S2
  always_comb begin
    w_xor = '0;
    for (int k = 0; k < NCH; k++) w_xor = w_xor ^ w_res[k*WIDTH +: WIDTH];
  end

  // S1: capture operands on accept, empty when the bundle moves to S2
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) r_s1_valid <= 1'b0;
    else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_a        <= a_i;
      r_b        <= b_i;
      r_op       <= op_i;
    end else if (w_adv2) r_s1_valid <= 1'b0;
  end

  // S2: register results and reductions together so they stall as one bundle
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      r_s2_valid <= 1'b0;
      r_res      <= '0;
      r_carry    <= '0;
      r_xor      <= '0;
      r_par      <= 1'b0;
    end else if (w_adv2) begin
      r_s2_valid <= 1'b1;
      r_res      <= w_res;
      r_carry    <= w_carry;
      r_xor      <= w_xor;
      r_par      <= ^w_xor;
    end else if (out_ready) r_s2_valid <= 1'b0;
  end
endmodule

// File: tb/tb_alu_pipe_nch.sv
// tb_alu_pipe_nch: scoreboard bench for the two-channel 8-bit configuration
module tb_alu_pipe_nch;
  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
  localparam logic [2:0] XOR_ = 3'b100, XNOR_ = 3'b101, ACC = 3'b110, MAX = 3'b111;

  typedef struct packed {
    logic [15:0] res;
    logic [1:0]  carry;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, acc_clr, out_valid, out_ready, par;
  logic [15:0] a, b, res;
  logic [5:0]  op;
  logic [1:0]  carry;
  logic [7:0]  xo;
  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          tries;

  always #5 clk = ~clk;

  alu_pipe_nch #(.WIDTH(8), .NCH(2), .ACC_EN(1)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_i(a), .b_i(b), .op_i(op), .acc_clr_i(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .res_o(res), .carry_o(carry), .xor_o(xo), .par_o(par)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every transfer and checks outputs hold while stalled
  initial begin
    logic [15:0] h_res;
    logic [1:0]  h_c;
    logic [7:0]  h_x, e_x;
    logic        h_p;
    logic        h_stall;
    exp_t        e;
    h_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) h_stall = 1'b0;
      else begin
        if (h_stall && out_valid) begin
          check("hold_res", res, h_res);
          check("hold_carry", carry, h_c);
          check("hold_xor", xo, h_x);
          check("hold_par", par, h_p);
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got res %h expected no output", res);
          end else begin
            e   = q.pop_front();
            e_x = e.res[7:0] ^ e.res[15:8];
            check("res", res, e.res);
            check("carry", carry, e.carry);
            check("xor", xo, e_x);
            check("par", par, ^e_x);
          end
        end
        h_stall = out_valid && !out_ready;
        h_res   = res;
        h_c     = carry;
        h_x     = xo;
        h_p     = par;
      end
    end
  end

  // present one bundle until accepted; the expected response is queued at the accepting edge
  task automatic send(input logic [7:0] a0, b0, input logic [2:0] o0,
                      input logic [7:0] a1, b1, input logic [2:0] o1,
                      input logic [7:0] r0, input logic c0, input logic [7:0] r1, input logic c1,
                      output int n);
    logic ok;
    a = {a1, a0};
    b = {b1, b0};
    op = {o1, o0};
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      n++;
      if (ok) q.push_back(exp_t'({r1, r0, c1, c0}));
      @(posedge clk);
      #1;
    end while (!ok && n < 50);
    in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready 0 for %0d cycles expected accept", n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (q.size() != 0 && n < 30);
    #1;
    check("drain_pending", q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; acc_clr = 1'b0;
    a = '0; b = '0; op = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_res", res, 0);
    check("rst_carry", carry, 0);
    check("rst_xor", xo, 0);
    check("rst_par", par, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);
    check("rel_out_valid", out_valid, 0);
    @(posedge clk); #1;

    send(8'hF0, 8'h20, ADD, 8'h05, 8'h07, SUB, 8'h10, 1, 8'hFE, 0, tries);
    @(negedge clk);
    check("lat_first_edge", out_valid, 0);
    @(negedge clk);
    check("lat_second_edge", out_valid, 1);
    drain();

    send(8'h01, 8'h02, ADD, 8'hF0, 8'h3C, AND_, 8'h03, 0, 8'h30, 0, tries);
    check("b2b_ready1", tries, 1);
    send(8'h10, 8'h10, SUB, 8'h0F, 8'h30, OR_, 8'h00, 1, 8'h3F, 0, tries);
    check("b2b_ready2", tries, 1);
    send(8'hFF, 8'h01, ADD, 8'hAA, 8'hFF, XOR_, 8'h00, 1, 8'h55, 0, tries);
    check("b2b_ready3", tries, 1);
    send(8'h00, 8'h01, SUB, 8'h0F, 8'h0F, XNOR_, 8'hFF, 0, 8'hFF, 0, tries);
    check("b2b_ready4", tries, 1);
    @(negedge clk);
    check("b2b_valid3", out_valid, 1);
    @(negedge clk);
    check("b2b_valid4", out_valid, 1);
    @(negedge clk);
    check("b2b_no_dup", out_valid, 0);
    drain();

    out_ready = 1'b0;
    send(8'h11, 8'h22, ADD, 8'h80, 8'h80, ADD, 8'h33, 0, 8'h00, 1, tries);
    send(8'h10, 8'h20, MAX, 8'h20, 8'h10, MAX, 8'h20, 0, 8'h20, 1, tries);
    check("bp_second_accept", tries, 1);
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    @(posedge clk); #1;
    fork
      begin
        send(8'h80, 8'h7F, SUB, 8'hFF, 8'h81, AND_, 8'h01, 1, 8'h81, 0, tries);
        send(8'h00, 8'h00, OR_, 8'h00, 8'hFF, XNOR_, 8'h00, 0, 8'h00, 0, tries);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    send(8'hA5, 8'h5A, AND_, 8'h33, 8'h33, MAX, 8'h00, 0, 8'h33, 0, tries);
    send(8'hA5, 8'h5A, OR_, 8'h33, 8'h33, ADD, 8'hFF, 0, 8'h66, 0, tries);
    send(8'hA5, 8'h5A, XOR_, 8'h33, 8'h33, XOR_, 8'hFF, 0, 8'h00, 0, tries);
    send(8'hA5, 8'h5A, XNOR_, 8'h33, 8'h33, XNOR_, 8'h00, 0, 8'hFF, 0, tries);
    send(8'hA5, 8'h5A, MAX, 8'h33, 8'h33, SUB, 8'hA5, 1, 8'h00, 1, tries);
    drain();

    send(8'h80, 8'h00, ACC, 8'h00, 8'h00, ADD, 8'h80, 0, 8'h00, 0, tries);
    send(8'h80, 8'h00, ACC, 8'h00, 8'h00, ADD, 8'h00, 1, 8'h00, 0, tries);
    send(8'h01, 8'h00, ACC, 8'h00, 8'h00, ADD, 8'h01, 0, 8'h00, 0, tries);
    send(8'h05, 8'h00, ACC, 8'h00, 8'h00, ADD, 8'h05, 0, 8'h00, 0, tries);
    acc_clr = 1'b1;
    @(posedge clk); #1 acc_clr = 1'b0;
    drain();

    out_ready = 1'b0;
    send(8'h01, 8'h01, ADD, 8'h02, 8'h02, ADD, 8'h02, 0, 8'h04, 0, tries);
    send(8'h03, 8'h03, ADD, 8'h04, 8'h04, ADD, 8'h06, 0, 8'h08, 0, tries);
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_res", res, 0);
    check("mid_rst_in_ready2", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_no_pulse", out_valid, 0);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    send(8'h07, 8'h00, ACC, 8'h40, 8'h40, ADD, 8'h07, 0, 8'h80, 0, tries);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_pipe_nch.md
Name: alu_pipe_nch

Overview:
- Parametrised, multi-channel, pipelined ALU. Next generation of the dual 8-bit ALU user macro.
- Generalises channel count and width, widens the opcode to 3 bits, and adds a per-channel accumulator.
- Adds a valid/ready handshake with backpressure and registered XOR-reduction and parity outputs.
- Sits inside a user macro; its ports are driven from io_in/io_out slices or from a Wishbone-side register block.

Parameters:
- WIDTH, 8, operand and result width per channel (≥2).
- NCH, 2, number of independent ALU channels (≥1).
- ACC_EN, 1, 1 enables the per-channel accumulator; 0 makes op 110 behave as op 000.

Ports:
- wb_clk_i  in  1  single clock, rising edge.
- wb_rst_n_i  in  1  synchronous active-low reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- a_i  in  NCH*WIDTH  operand A; channel k = bits [k*WIDTH +: WIDTH].
- b_i  in  NCH*WIDTH  operand B, same packing.
- op_i  in  NCH*3  per-channel opcode; channel k = bits [k*3 +: 3].
- acc_clr_i  in  1  clear all accumulators.
- out_valid  out  1  result bundle valid.
- out_ready  in  1  consumer accepts the result.
- res_o  out  NCH*WIDTH  per-channel result.
- carry_o  out  NCH  per-channel carry/flag.
- xor_o  out  WIDTH  XOR of all NCH results in the same bundle.
- par_o  out  1  XOR of all bits of xor_o.

Behaviour:
- Reset: while wb_rst_n_i=0 at a clock edge, clear s1_valid, s2_valid, all accumulators, res_o, carry_o, xor_o and par_o to 0. in_ready is forced 0 combinationally while wb_rst_n_i=0. First cycle after reset release: in_ready=1, out_valid=0.
- Pipeline stages:
  - S1 registers a_i, b_i and op_i.
  - S2 computes and registers all outputs.
  - out_valid is the S2 valid flag.
- Advance rules:
  - adv2 = s1_valid & (!s2_valid | out_ready).
  - in_ready = wb_rst_n_i & (!s1_valid | adv2).
  - Accept happens when in_valid & in_ready.
- Latency: accept at edge N gives out_valid=1 after edge N+1. Full throughput is 1 bundle/cycle while out_ready=1.
- Stall: while out_valid & !out_ready, res_o, carry_o, xor_o and par_o hold stable. Once S1 is also full, in_ready=0 and nothing is dropped or duplicated.
- If S2 is drained (out_ready=1) in the same cycle S1 refills it, the new data loads with no bubble.
- Opcodes, per channel. All arithmetic is unsigned modulo 2^WIDTH; carry is bit WIDTH of the (WIDTH+1)-bit result.
  - 000 ADD: res = A+B, carry = carry-out.
  - 001 SUB: res = A−B, carry = 1 iff A≥B (no borrow).
  - 010 AND: res = A&B, carry = 0.
  - 011 OR: res = A|B, carry = 0.
  - 100 XOR: res = A^B, carry = 0.
  - 101 XNOR: res = ~(A^B), carry = 0.
  - 110 ACC: acc_new = (acc_clr_i ? 0 : acc) + A; res = acc_new[WIDTH-1:0]; carry = acc_new carry-out. The accumulator is updated only on the adv2 cycle.
  - 111 MAX: res = (A≥B) ? A : B, carry = 1 iff A>B.
- Accumulator rules:
  - acc_clr_i is sampled every cycle, independent of the handshake.
  - Without an ACC op advancing that cycle, all accumulators go to 0.
  - When simultaneous with an ACC advance, clear is applied first, so acc = A.
  - Accumulator wrap-around is silent apart from carry.
- Reduction outputs: xor_o and par_o are computed from the same bundle's results and registered with res_o (same cycle, same stall behaviour).
- Reset mid-operation: in-flight S1 and S2 bundles are discarded. No out_valid pulse for them after reset.

Test Plan:
- WIDTH=8, NCH=2. ch0 ADD A=0xF0 B=0x20; ch1 SUB A=0x05 B=0x07 -> 2 cycles later: res ch0=0x10, carry0=1; ch1=0xFE, carry1=0; xor_o=0xEE; par_o=0.
- Back-to-back: 4 bundles on consecutive cycles with out_ready=1 -> 4 consecutive out_valid cycles, in order, in_ready constantly 1.
- Backpressure: out_ready=0 for 5 cycles while streaming -> in_ready drops after 2 accepts; outputs hold; release out_ready -> all bundles delivered, no loss or duplicate.
- ACC: ch0 op 110 with A=0x80, 0x80, 0x01 -> res 0x80 c0; 0x00 c1; 0x01 c0. Then acc_clr_i with an ACC A=0x05 in the same cycle -> res 0x05.
- Logic and MAX: A=0xA5 B=0x5A -> AND 0x00, OR 0xFF, XOR 0xFF, XNOR 0x00, MAX 0xA5 carry 1; with A=B=0x33, MAX carry=0.
- Reset mid-stream: assert wb_rst_n_i=0 with S1 and S2 full -> next cycle out_valid=0, res_o=0, in_ready=0. After release, first new result is correct and accumulators read 0.
